util_cpack_timestamp_n: RTL and testbench

UTIL_CPACK_TIMESTAMP_N -- requirements
Module: util_cpack_timestamp_n

---
 rtl/util_cpack_timestamp_n.sv | 199 +++++++++++++++++++
 tb/tb_util_cpack_timestamp_n.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/util_cpack_timestamp_n.sv
// Packs enabled 16-bit channels into 64-bit words, optionally prefixing each block
// of captures with a magic header word and the timestamp of its first capture.
module util_cpack_timestamp_n #(
  parameter int          NUM_OF_CHANNELS  = 4,
  parameter logic [63:0] TIMESTAMP_MAGIC  = 64'h504D5453454D4954,
  parameter int          DROP_COUNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [63:0]                   timestamp,
  input  logic [31:0]                   timestamp_every,
  input  logic [NUM_OF_CHANNELS-1:0]    enable,
  input  logic                          fifo_wr_en,
  input  logic [16*NUM_OF_CHANNELS-1:0] fifo_wr_data,
  output logic                          fifo_wr_overflow,
  output logic                          packed_fifo_wr_en,
  output logic                          packed_fifo_wr_sync,
  output logic [63:0]                   packed_fifo_wr_data,
  input  logic                          packed_fifo_wr_overflow,
  output logic [DROP_COUNT_WIDTH-1:0]   dropped_count
);

  localparam logic [2:0] ST_RESET     = 3'd0;
  localparam logic [2:0] ST_WAIT      = 3'd1;
  localparam logic [2:0] ST_FLUSH     = 3'd2;
  localparam logic [2:0] ST_TS_HEADER = 3'd3;
  localparam logic [2:0] ST_TS_VALUE  = 3'd4;
  localparam logic [2:0] ST_STORE     = 3'd5;
  localparam logic [2:0] ST_OUTPUT    = 3'd6;

  logic [2:0]                    state_q, state_d;
  logic [NUM_OF_CHANNELS-1:0]    enable_q, enable_d;
  logic [16*NUM_OF_CHANNELS-1:0] data_q, data_d;
  logic [63:0]                   ts_q, ts_d;
  logic [31:0]                   counter_q, counter_d;
  logic [2:0]                    index_in_q, index_in_d;
  logic [1:0]                    index_out_q, index_out_d;
  logic [63:0]                   packed_q, packed_d;
  logic                          lane0_first_q, lane0_first_d;
  logic                          drop_pulse_q, drop_pulse_d;
  logic [DROP_COUNT_WIDTH-1:0]   dropped_q, dropped_d;

  logic [3:0]  en_count;
  logic [3:0]  run;
  logic [15:0] sel_data;
  logic [63:0] flush_data;
  logic        resync, capture, drop, last_in;

  // Walk the enables once: total count, and the channel whose rank equals index_in.
  always_comb begin
    run      = 4'd0;
    sel_data = 16'd0;
    for (int i = 0; i < NUM_OF_CHANNELS; i++) begin
      if (enable_q[i] && (run == {1'b0, index_in_q}))
        sel_data = data_q[16*i +: 16];
      run = run + {3'd0, enable_q[i]};
    end
    en_count = run;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_flush
    assign flush_data[16*gi +: 16] = (2'(gi) < index_out_q) ? packed_q[16*gi +: 16] : 16'd0;
  end

  assign resync  = (enable != enable_q);
  assign last_in = ({1'b0, index_in_q} == (en_count - 4'd1));
  assign capture = (state_q == ST_WAIT) && fifo_wr_en && (en_count != 4'd0) && !resync;
  assign drop    = fifo_wr_en && (state_q != ST_WAIT) && (state_q != ST_RESET);

  always_comb begin
    state_d       = state_q;
    enable_d      = enable;
    data_d        = data_q;
    ts_d          = ts_q;
    counter_d     = counter_q;
    index_in_d    = index_in_q;
    index_out_d   = index_out_q;
    packed_d      = packed_q;
    lane0_first_d = lane0_first_q;
    drop_pulse_d  = drop;
    dropped_d     = dropped_q;

    if (drop && (dropped_q != {DROP_COUNT_WIDTH{1'b1}}))
      dropped_d = dropped_q + 1'b1;

    case (state_q)
      ST_RESET: begin
        index_in_d    = 3'd0;
        index_out_d   = 2'd0;
        counter_d     = 32'd0;
        packed_d      = 64'd0;
        lane0_first_d = 1'b0;
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        if (capture) begin
          data_d = fifo_wr_data;
          if (timestamp_every != 32'd0) begin
            counter_d = (counter_q >= timestamp_every - 32'd1) ? 32'd0 : counter_q + 32'd1;
            if (counter_q == 32'd0) begin
              ts_d    = timestamp;
              state_d = (index_out_q != 2'd0) ? ST_FLUSH : ST_TS_HEADER;
            end else begin
              state_d = ST_STORE;
            end
          end else begin
            if (index_out_q == 2'd0)
              ts_d = timestamp;
            state_d = ST_STORE;
          end
        end
      end
      ST_FLUSH: begin
        index_out_d = 2'd0;
        state_d     = ST_TS_HEADER;
      end
      ST_TS_HEADER: state_d = ST_TS_VALUE;
      ST_TS_VALUE:  state_d = ST_STORE;
      ST_STORE: begin
        for (int k = 0; k < 4; k++) begin
          if (index_out_q == 2'(k))
            packed_d[16*k +: 16] = sel_data;
        end
        // Lane 0 carrying a capture's first channel is what marks an aligned word.
        if (index_out_q == 2'd0)
          lane0_first_d = (index_in_q == 3'd0);
        index_out_d = index_out_q + 2'd1;
        index_in_d  = last_in ? 3'd0 : index_in_q + 3'd1;
        if (index_out_q == 2'd3)
          state_d = ST_OUTPUT;
        else if (last_in)
          state_d = ST_WAIT;
      end
      ST_OUTPUT: state_d = (index_in_q != 3'd0) ? ST_STORE : ST_WAIT;
      default:   state_d = ST_RESET;
    endcase

    if (resync)
      state_d = ST_RESET;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RESET;
      enable_q      <= '0;
      data_q        <= '0;
      ts_q          <= 64'd0;
      counter_q     <= 32'd0;
      index_in_q    <= 3'd0;
      index_out_q   <= 2'd0;
      packed_q      <= 64'd0;
      lane0_first_q <= 1'b0;
      drop_pulse_q  <= 1'b0;
      dropped_q     <= '0;
    end else begin
      state_q       <= state_d;
      enable_q      <= enable_d;
      data_q        <= data_d;
      ts_q          <= ts_d;
      counter_q     <= counter_d;
      index_in_q    <= index_in_d;
      index_out_q   <= index_out_d;
      packed_q      <= packed_d;
      lane0_first_q <= lane0_first_d;
      drop_pulse_q  <= drop_pulse_d;
      dropped_q     <= dropped_d;
    end
  end

  always_comb begin
    packed_fifo_wr_en   = 1'b0;
    packed_fifo_wr_sync = 1'b0;
    packed_fifo_wr_data = packed_q;
    case (state_q)
      ST_FLUSH: begin
        packed_fifo_wr_en   = 1'b1;
        packed_fifo_wr_data = flush_data;
      end
      ST_TS_HEADER: begin
        packed_fifo_wr_en   = 1'b1;
        packed_fifo_wr_sync = 1'b1;
        packed_fifo_wr_data = TIMESTAMP_MAGIC;
      end
      ST_TS_VALUE: begin
        packed_fifo_wr_en   = 1'b1;
        packed_fifo_wr_data = ts_q;
      end
      ST_OUTPUT: begin
        packed_fifo_wr_en   = 1'b1;
        packed_fifo_wr_sync = (timestamp_every == 32'd0) && lane0_first_q;
      end
      default: ;
    endcase
  end

  assign fifo_wr_overflow = packed_fifo_wr_overflow | drop_pulse_q;
  assign dropped_count    = dropped_q;

endmodule

// File: tb/tb_util_cpack_timestamp_n.sv
// Directed bench: three packer instances (4 ch, 3 ch, 4 ch with 2-bit drop counter)
// checked against hand-computed output word sequences.
module tb_util_cpack_timestamp_n;

  localparam logic [63:0] MAGIC = 64'h504D5453454D4954;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] timestamp;
  logic [31:0] timestamp_every;
  logic [3:0]  enable4;
  logic [2:0]  enable3;
  logic        fifo_wr_en;
  logic [63:0] wr_data4;
  logic [47:0] wr_data3;
  logic        pkt_ovf;

  logic        ovf4, en4, sync4;
  logic [63:0] data4;
  logic [15:0] drop4;
  logic        ovf3, en3, sync3;
  logic [63:0] data3;
  logic [15:0] drop3;
  logic        ovfw, enw, syncw;
  logic [63:0] dataw;
  logic [1:0]  dropw;

  int n_checks = 0;
  int n_fail   = 0;
  int ovf_cycles4 = 0;
  logic [64:0] q4[$];
  logic [64:0] q3[$];

  always #5 clk = ~clk;

  util_cpack_timestamp_n #(.NUM_OF_CHANNELS(4)) u_dut4 (
    .clk(clk), .reset(reset), .timestamp(timestamp), .timestamp_every(timestamp_every),
    .enable(enable4), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(wr_data4),
    .fifo_wr_overflow(ovf4), .packed_fifo_wr_en(en4), .packed_fifo_wr_sync(sync4),
    .packed_fifo_wr_data(data4), .packed_fifo_wr_overflow(pkt_ovf), .dropped_count(drop4)
  );

  util_cpack_timestamp_n #(.NUM_OF_CHANNELS(3)) u_dut3 (
    .clk(clk), .reset(reset), .timestamp(timestamp), .timestamp_every(timestamp_every),
    .enable(enable3), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(wr_data3),
    .fifo_wr_overflow(ovf3), .packed_fifo_wr_en(en3), .packed_fifo_wr_sync(sync3),
    .packed_fifo_wr_data(data3), .packed_fifo_wr_overflow(pkt_ovf), .dropped_count(drop3)
  );

  util_cpack_timestamp_n #(.NUM_OF_CHANNELS(4), .DROP_COUNT_WIDTH(2)) u_dut_w2 (
    .clk(clk), .reset(reset), .timestamp(timestamp), .timestamp_every(timestamp_every),
    .enable(enable4), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(wr_data4),
    .fifo_wr_overflow(ovfw), .packed_fifo_wr_en(enw), .packed_fifo_wr_sync(syncw),
    .packed_fifo_wr_data(dataw), .packed_fifo_wr_overflow(pkt_ovf), .dropped_count(dropw)
  );

  // Record every emitted word as {sync, data}, sampled mid-cycle.
  always @(negedge clk) begin
    if (en4) q4.push_back({sync4, data4});
    if (en3) q3.push_back({sync3, data3});
    if (ovf4) ovf_cycles4++;
  end

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  function automatic logic [64:0] q4_at(int i);
    return (i < q4.size()) ? q4[i] : 65'bx;
  endfunction

  function automatic logic [64:0] q3_at(int i);
    return (i < q3.size()) ? q3[i] : 65'bx;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    pkt_ovf = 1'b1;
    idle(3);
    check("rst_wr_en", {64'd0, en4}, 65'd0);
    check("rst_sync", {64'd0, sync4}, 65'd0);
    check("rst_ovf_passthru", {64'd0, ovf4}, 65'd1);
    check("rst_dropped", {49'd0, drop4}, 65'd0);
    pkt_ovf = 1'b0;
    #1;
    check("rst_ovf_low", {64'd0, ovf4}, 65'd0);
    reset = 1'b0;
    idle(4);
    q4.delete();
    q3.delete();
    ovf_cycles4 = 0;
  endtask

  task automatic capture(input logic [63:0] d4, input logic [47:0] d3);
    fifo_wr_en = 1'b1;
    wr_data4   = d4;
    wr_data3   = d3;
    @(posedge clk);
    #1;
    fifo_wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pkt_ovf = 1'b0; fifo_wr_en = 1'b0;
    timestamp = 64'd0; timestamp_every = 32'd0;
    enable4 = 4'hF; enable3 = 3'b111;
    wr_data4 = 64'd0; wr_data3 = 48'd0;

    // Plain packing, all four channels, no timestamps.
    do_reset();
    capture(64'h0004_0003_0002_0001, 48'd0);
    idle(8);
    capture(64'h0008_0007_0006_0005, 48'd0);
    idle(8);
    check("pack_count", 65'(q4.size()), 65'd2);
    check("pack_word0", q4_at(0), {1'b1, 64'h0004_0003_0002_0001});
    check("pack_word1", q4_at(1), {1'b1, 64'h0008_0007_0006_0005});

    // Channels 0 and 2 only, header every two captures.
    enable4 = 4'b0101;
    timestamp_every = 32'd2;
    do_reset();
    timestamp = 64'd100;
    capture(64'h0A03_0A02_0A01_0A00, 48'd0);
    idle(8);
    timestamp = 64'd200;
    capture(64'h0B03_0B02_0B01_0B00, 48'd0);
    idle(8);
    check("ts_count", 65'(q4.size()), 65'd3);
    check("ts_header", q4_at(0), {1'b1, MAGIC});
    check("ts_value", q4_at(1), {1'b0, 64'd100});
    check("ts_word", q4_at(2), {1'b0, 64'h0B02_0B00_0A02_0A00});

    // Three channels, header every capture: second block flushes a part-filled word.
    timestamp_every = 32'd1;
    do_reset();
    timestamp = 64'd300;
    capture(64'd0, 48'h0C02_0C01_0C00);
    idle(8);
    timestamp = 64'd400;
    capture(64'd0, 48'h0D02_0D01_0D00);
    idle(10);
    check("flush_count", 65'(q3.size()), 65'd5);
    check("flush_hdr0", q3_at(0), {1'b1, MAGIC});
    check("flush_ts0", q3_at(1), {1'b0, 64'd300});
    check("flush_word", q3_at(2), {1'b0, 64'h0000_0C02_0C01_0C00});
    check("flush_hdr1", q3_at(3), {1'b1, MAGIC});
    check("flush_ts1", q3_at(4), {1'b0, 64'd400});
    check("flush_dropped", {49'd0, drop3}, 65'd0);

    // Strobe held 3 cycles: one capture, two drops.
    enable4 = 4'hF;
    timestamp_every = 32'd0;
    do_reset();
    fifo_wr_en = 1'b1;
    wr_data4 = 64'h0014_0013_0012_0011;
    idle(3);
    fifo_wr_en = 1'b0;
    idle(8);
    check("drop_count", {49'd0, drop4}, 65'd2);
    check("drop_ovf_cycles", 65'(ovf_cycles4), 65'd2);
    check("drop_words", 65'(q4.size()), 65'd1);
    check("drop_word0", q4_at(0), {1'b1, 64'h0014_0013_0012_0011});

    // Strobe held 6 cycles: five drops saturate the 2-bit counter.
    do_reset();
    fifo_wr_en = 1'b1;
    wr_data4 = 64'h0024_0023_0022_0021;
    idle(6);
    fifo_wr_en = 1'b0;
    idle(4);
    check("sat_w2", {63'd0, dropw}, 65'd3);
    check("sat_w16", {49'd0, drop4}, 65'd5);
    check("sat_ovf_cycles", 65'(ovf_cycles4), 65'd5);

    // Enable changes mid-store: partial block discarded, restart with a header.
    timestamp_every = 32'd2;
    do_reset();
    timestamp = 64'd500;
    capture(64'h0023_0022_0021_0020, 48'd0);
    idle(3);
    enable4 = 4'h3;
    idle(6);
    timestamp = 64'd600;
    capture(64'h0033_0032_0031_0030, 48'd0);
    idle(8);
    timestamp = 64'd700;
    capture(64'h0043_0042_0041_0040, 48'd0);
    idle(8);
    check("resync_count", 65'(q4.size()), 65'd5);
    check("resync_hdr0", q4_at(0), {1'b1, MAGIC});
    check("resync_ts0", q4_at(1), {1'b0, 64'd500});
    check("resync_hdr1", q4_at(2), {1'b1, MAGIC});
    check("resync_ts1", q4_at(3), {1'b0, 64'd600});
    check("resync_word", q4_at(4), {1'b0, 64'h0041_0040_0031_0030});
    check("resync_dropped", {49'd0, drop4}, 65'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
